result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader_pkg.sv | 18 +
 rtl/result_fifo2.sv | 57 +++++
 rtl/result_reader.sv | 131 +++++++++++++
 tb/tb_result_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_reader_pkg.sv
// Shared definitions for the result reader.
//   ADDR_W / DATA_W : default output-memory address and distance word widths
//   INF             : distance value meaning "unreachable" (all ones)
//   state_t         : controller states
package result_reader_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] INF = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO holding stream words ahead of the consumer.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   push         : write push_data (caller guarantees space)
//   pop          : remove head (caller guarantees non-empty)
//   head         : registered head entry (slot0)
//   count        : number of stored entries, 0..2
module result_fifo2
  import result_reader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;

  // slot0 is always the head, so the outputs come straight from flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // with one entry the new word becomes the head directly
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/result_reader.sv
// Streams node_count distance words out of the output memory, tagging each
// with its node index, an INF flag and a last flag. A start with the solver's
// negative-cycle flag set (or a zero count) completes without streaming.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   start               : one-cycle request, honoured only in IDLE
//   node_count          : words to stream, sampled with start
//   neg_cycle           : solver NegCycle flag, sampled with start
//   OMAR / OMDR         : output-memory address / same-cycle read data
//   out_valid/out_ready : stream handshake
//   out_data, out_index, out_inf, out_last : stream word and tags
//   busy                : controller not in IDLE
//   done                : one-cycle completion pulse
//   neg_flag            : neg_cycle latched at the last accepted start
module result_reader #(
  parameter int ADDR_W    = result_reader_pkg::ADDR_W,
  parameter int DATA_W    = result_reader_pkg::DATA_W,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] node_count,
  input  logic              neg_cycle,
  output logic [ADDR_W-1:0] OMAR,
  input  logic [DATA_W-1:0] OMDR,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_inf,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              neg_flag
);
  import result_reader_pkg::*;

  localparam int                FW   = DATA_W + ADDR_W + 2;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] omar_q;
  logic              done_q;
  logic              neg_q;

  logic              push;
  logic              pop;
  logic              space;
  logic              at_last;
  logic [1:0]        fifo_count;
  logic [FW-1:0]     push_word;
  logic [FW-1:0]     head_word;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign space     = (fifo_count != 2'd2) | pop;
  // comparing against count-1 keeps index below 2^ADDR_W for the max count
  assign at_last   = (index == count_q - ONE);
  assign push_word = {OMDR, index, (OMDR == ALL_ONES), at_last};

  always_comb begin
    state_next = state;
    push       = 1'b0;
    OMAR       = omar_q;
    unique case (state)
      IDLE: begin
        if (start)
          state_next = (node_count != '0 && !neg_cycle) ? READ : DONE;
      end
      READ: begin
        if (space) begin
          push = 1'b1;
          OMAR = BASE + index;
          if (at_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop))
          state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      index   <= '0;
      count_q <= '0;
      omar_q  <= '0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state  <= state_next;
      omar_q <= OMAR;
      // done is registered, so the pulse lands the cycle after DONE
      done_q <= (state == DONE);
      if (state == IDLE && start) begin
        index   <= '0;
        count_q <= node_count;
        neg_q   <= neg_cycle;
      end else if (push) begin
        index <= index + ONE;
      end
    end
  end

  result_fifo2 #(.W(FW)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_word),
    .pop      (pop),
    .head     (head_word),
    .count    (fifo_count)
  );

  assign out_data  = head_word[FW-1 -: DATA_W];
  assign out_index = head_word[ADDR_W+1 -: ADDR_W];
  assign out_inf   = head_word[1];
  assign out_last  = head_word[0];
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign neg_flag  = neg_q;

endmodule

// File: tb/tb_result_reader.sv
module tb_result_reader;

  localparam int AW   = 13;
  localparam int DW   = 16;
  localparam int BASE = 8190;

  logic          clock;
  logic          reset;
  logic          start;
  logic [AW-1:0] node_count;
  logic          neg_cycle;
  logic [AW-1:0] OMAR;
  logic [DW-1:0] OMDR;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_inf;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          neg_flag;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp;
  int n_bad;

  result_reader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .node_count(node_count),
    .neg_cycle (neg_cycle),
    .OMAR      (OMAR),
    .OMDR      (OMDR),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_inf   (out_inf),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .neg_flag  (neg_flag)
  );

  assign OMDR = mem[OMAR];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [AW-1:0] addr(input int i);
    addr = AW'(BASE + i);
  endfunction

  task automatic wr(input int i, input logic [DW-1:0] v);
    mem[addr(i)] = v;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // returns in cycle 1 (start was presented in cycle 0)
  task automatic do_start(input logic [AW-1:0] nc, input logic ng);
    start = 1'b1; node_count = nc; neg_cycle = ng;
    step();
    start = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; node_count = '0; neg_cycle = 1'b0; out_ready = 1'b1;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (OMAR !== '0) begin n_bad++; $display("FAIL reset_omar: got %h want 0", OMAR); end
    n_cmp++; if ({out_data, out_index, out_inf, out_last, neg_flag} !== '0) begin
      n_bad++; $display("FAIL reset_outs: got %h/%h/%b/%b/%b want zeros", out_data, out_index, out_inf, out_last, neg_flag);
    end
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_node_count();
    logic [DW-1:0] ev [4];
    int idx;
    logic exp_v;
    ev = '{16'd5, 16'd0, 16'hFFFF, 16'd12};
    for (int i = 0; i < 4; i++) wr(i, ev[i]);
    out_ready = 1'b1;
    do_start(AW'(4), 1'b0);
    for (int c = 1; c <= 8; c++) begin
      exp_v = (c >= 2 && c <= 5);
      if (c == 1) begin
        n_cmp++; if (OMAR !== addr(0)) begin n_bad++; $display("FAIL nc_omar_c1: got %h want %h", OMAR, addr(0)); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nc_busy_c1: got %b want 1", busy); end
      end
      n_cmp++; if (out_valid !== exp_v) begin n_bad++; $display("FAIL nc_valid c%0d: got %b want %b", c, out_valid, exp_v); end
      if (exp_v) begin
        idx = c - 2;
        n_cmp++; if (out_index !== AW'(idx)) begin n_bad++; $display("FAIL nc_index c%0d: got %0d want %0d", c, out_index, idx); end
        n_cmp++; if (out_data !== ev[idx]) begin n_bad++; $display("FAIL nc_data c%0d: got %h want %h", c, out_data, ev[idx]); end
        n_cmp++; if (out_inf !== (idx == 2)) begin n_bad++; $display("FAIL nc_inf c%0d: got %b want %b", c, out_inf, idx == 2); end
        n_cmp++; if (out_last !== (idx == 3)) begin n_bad++; $display("FAIL nc_last c%0d: got %b want %b", c, out_last, idx == 3); end
      end
      n_cmp++; if (done !== (c == 7)) begin n_bad++; $display("FAIL nc_done c%0d: got %b want %b", c, done, c == 7); end
      if (c == 8) begin
        n_cmp++; if (OMAR !== addr(3)) begin n_bad++; $display("FAIL nc_omar_hold: got %h want %h", OMAR, addr(3)); end
      end
      if (c < 8) step();
    end
    settle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] ev [3];
    int k;
    int done_cyc;
    ev = '{16'h0011, 16'h0022, 16'h0033};
    for (int i = 0; i < 3; i++) wr(i, ev[i]);
    k = 0; done_cyc = -1;
    out_ready = 1'b1;
    do_start(AW'(3), 1'b0);
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      out_ready = !(c >= 2 && c <= 6);
      #1;
      if (c >= 2 && c <= 6) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== ev[0] || out_index !== '0) begin
          n_bad++; $display("FAIL bp_hold c%0d: got v=%b d=%h i=%0d want v=1 d=%h i=0", c, out_valid, out_data, out_index, ev[0]);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (k > 2 || out_data !== ev[k] || out_index !== AW'(k)) begin
          n_bad++; $display("FAIL bp_order #%0d: got d=%h i=%0d", k, out_data, out_index);
        end
        k++;
      end
      if (done) done_cyc = c;
      if (done_cyc < 0) step();
    end
    n_cmp++; if (k != 3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", k); end
    n_cmp++; if (done_cyc != 11) begin n_bad++; $display("FAIL bp_done_cycle: got %0d want 11", done_cyc); end
    out_ready = 1'b1;
    settle();
  endtask

  task automatic test_neg_cycle();
    do_start(AW'(8), 1'b1);
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL neg_c1: got busy=%b v=%b done=%b want 1/0/0", busy, out_valid, done);
    end
    n_cmp++; if (neg_flag !== 1'b1) begin n_bad++; $display("FAIL neg_flag: got %b want 1", neg_flag); end
    step();
    n_cmp++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL neg_c2: got done=%b v=%b want 1/0", done, out_valid);
    end
    step();
    n_cmp++; if (done !== 1'b0 || out_valid !== 1'b0 || neg_flag !== 1'b1) begin
      n_bad++; $display("FAIL neg_c3: got done=%b v=%b nf=%b want 0/0/1", done, out_valid, neg_flag);
    end
    settle();
  endtask

  task automatic test_zero_count();
    do_start(AW'(0), 1'b0);
    n_cmp++; if (neg_flag !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_c1: got nf=%b done=%b v=%b want 0/0/0", neg_flag, done, out_valid);
    end
    step();
    n_cmp++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_c2: got done=%b v=%b want 1/0", done, out_valid);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) wr(i, DW'(16'h00A0 + i));
    out_ready = 1'b1;
    do_start(AW'(6), 1'b0);
    step(); step();
    n_cmp++; if (out_valid !== 1'b1 || out_index !== AW'(1)) begin
      n_bad++; $display("FAIL rm_word2: got v=%b i=%0d want 1/1", out_valid, out_index);
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || OMAR !== '0) begin
      n_bad++; $display("FAIL rm_async: got v=%b busy=%b omar=%h want 0/0/0", out_valid, busy, OMAR);
    end
    n_cmp++; if ({out_data, out_index, out_inf, out_last} !== '0) begin
      n_bad++; $display("FAIL rm_outs: got %h/%h/%b/%b want zeros", out_data, out_index, out_inf, out_last);
    end
    #2;
    reset = 1'b1;
    start = 1'b1; node_count = AW'(6); neg_cycle = 1'b0;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      n_cmp++; if (out_valid !== (c >= 2 && c <= 7)) begin
        n_bad++; $display("FAIL rm_valid c%0d: got %b want %b", c, out_valid, c >= 2 && c <= 7);
      end
      if (c >= 2 && c <= 7) begin
        n_cmp++; if (out_index !== AW'(c - 2) || out_data !== DW'(16'h00A0 + c - 2)) begin
          n_bad++; $display("FAIL rm_word c%0d: got i=%0d d=%h want i=%0d d=%h", c, out_index, out_data, c - 2, 16'h00A0 + c - 2);
        end
      end
      n_cmp++; if (done !== (c == 9)) begin n_bad++; $display("FAIL rm_done c%0d: got %b want %b", c, done, c == 9); end
      if (c < 9) step();
    end
    settle();
  endtask

  task automatic test_start_busy();
    for (int i = 0; i < 5; i++) wr(i, DW'(16'h00B0 + i));
    out_ready = 1'b1;
    do_start(AW'(5), 1'b0);
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) begin start = 1'b1; node_count = AW'(2); neg_cycle = 1'b1; end
      else start = 1'b0;
      n_cmp++; if (out_valid !== (c >= 2 && c <= 6)) begin
        n_bad++; $display("FAIL sb_valid c%0d: got %b want %b", c, out_valid, c >= 2 && c <= 6);
      end
      if (c >= 2 && c <= 6) begin
        n_cmp++; if (out_index !== AW'(c - 2) || out_data !== DW'(16'h00B0 + c - 2) || out_last !== (c == 6)) begin
          n_bad++; $display("FAIL sb_word c%0d: got i=%0d d=%h l=%b", c, out_index, out_data, out_last);
        end
      end
      n_cmp++; if (neg_flag !== 1'b0) begin n_bad++; $display("FAIL sb_negflag c%0d: got %b want 0", c, neg_flag); end
      n_cmp++; if (done !== (c == 8)) begin n_bad++; $display("FAIL sb_done c%0d: got %b want %b", c, done, c == 8); end
      step();
    end
    start = 1'b0;
    settle();
  endtask

  task automatic test_full_count();
    int n;
    int k;
    int bad;
    int seen_done;
    logic [DW-1:0] ev;
    n = (1 << AW) - 1;
    for (int i = 0; i < n; i++) wr(i, (i == 100) ? 16'hFFFF : DW'(i * 7 + 3));
    k = 0; bad = 0; seen_done = 0;
    out_ready = 1'b1;
    do_start(AW'(n), 1'b0);
    for (int c = 1; c <= n + 20 && seen_done == 0; c++) begin
      if (out_valid) begin
        ev = (k == 100) ? 16'hFFFF : DW'(k * 7 + 3);
        if (out_index !== AW'(k) || out_data !== ev || out_inf !== (k == 100) || out_last !== (k == n - 1)) bad++;
        k++;
      end
      if (done) seen_done = 1;
      step();
    end
    n_cmp++; if (k != n) begin n_bad++; $display("FAIL full_count: got %0d words want %0d", k, n); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL full_words: got %0d bad words want 0", bad); end
    n_cmp++; if (seen_done != 1) begin n_bad++; $display("FAIL full_done: got %0d want 1", seen_done); end
    settle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_node_count();
    test_backpressure();
    test_neg_cycle();
    test_zero_count();
    test_reset_mid();
    test_start_busy();
    test_full_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
